// File: rtl/vend_controller.sv
// Vending transaction sequencer: latches a selection, accumulates coin credit,
// and drives the dispense and change actuators through req/ack handshakes.
module vend_controller #(
   parameter int unsigned PRICE0      = 4,
   parameter int unsigned PRICE1      = 5,
   parameter int unsigned PRICE2      = 6,
   parameter int unsigned PRICE3      = 7,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sel_valid,
   input  logic [1:0] sel_item,
   input  logic       coin_valid,
   input  logic [1:0] coin_value,
   input  logic       cancel,
   output logic       vend_req,
   output logic [1:0] vend_item,
   input  logic       vend_ack,
   output logic       chg_req,
   output logic [3:0] chg_amount,
   input  logic       chg_ack,
   output logic [3:0] credit,
   output logic       busy,
   output logic       coin_reject,
   output logic       timeout
);

   localparam int unsigned   TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      REFUND  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    item_q, item_d;
   logic [3:0]    price_q, price_d;
   logic [3:0]    change_q, change_d;
   logic [3:0]    credit_q, credit_d;
   logic [3:0]    chg_amount_q, chg_amount_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          coin_reject_q, coin_reject_d;
   logic          timeout_q, timeout_d;
   logic          vend_req_q;
   logic [1:0]    vend_item_q;
   logic          chg_req_q;
   logic          busy_q;

   logic          coin_ok;
   logic [3:0]    credit_sum;
   logic [TW-1:0] timer_inc;
   logic          tmo_hit;

   function automatic logic [3:0] price_of(input logic [1:0] idx);
      case (idx)
         2'd0:    price_of = 4'(PRICE0);
         2'd1:    price_of = 4'(PRICE1);
         2'd2:    price_of = 4'(PRICE2);
         default: price_of = 4'(PRICE3);
      endcase
   endfunction

   // A zero-valued coin strobe is not a coin: it neither credits nor restarts the timer.
   assign coin_ok    = coin_valid && (coin_value != 2'd0);
   assign credit_sum = credit_q + (coin_ok ? {2'b00, coin_value} : 4'd0);
   assign timer_inc  = timer_q + TW'(1);
   assign tmo_hit    = !coin_ok && (timer_inc == TLIM);

   always_comb begin
      state_d       = state_q;
      item_d        = item_q;
      price_d       = price_q;
      change_d      = change_q;
      credit_d      = credit_q;
      chg_amount_d  = chg_amount_q;
      timer_d       = timer_q;
      coin_reject_d = 1'b0;
      timeout_d     = 1'b0;

      case (state_q)
         IDLE: begin
            coin_reject_d = coin_ok;
            if (sel_valid) begin
               item_d  = sel_item;
               price_d = price_of(sel_item);
               timer_d = '0;
               state_d = COLLECT;
            end
         end

         COLLECT: begin
            // The coin is folded in first; reaching the price overrides cancel/timeout.
            credit_d = credit_sum;
            timer_d  = coin_ok ? '0 : timer_inc;
            if (credit_sum >= price_q) begin
               change_d = credit_sum - price_q;
               state_d  = VEND;
            end else if (cancel || tmo_hit) begin
               timeout_d = tmo_hit;
               timer_d   = '0;
               if (credit_sum != 4'd0) begin
                  chg_amount_d = credit_sum;
                  credit_d     = 4'd0;
                  state_d      = REFUND;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         VEND: begin
            coin_reject_d = coin_ok;
            if (vend_ack) begin
               credit_d = 4'd0;
               change_d = 4'd0;
               if (change_q != 4'd0) begin
                  chg_amount_d = change_q;
                  state_d      = REFUND;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         REFUND: begin
            coin_reject_d = coin_ok;
            credit_d      = 4'd0;
            if (chg_ack) begin
               chg_amount_d = 4'd0;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         item_q        <= 2'd0;
         price_q       <= 4'd0;
         change_q      <= 4'd0;
         credit_q      <= 4'd0;
         chg_amount_q  <= 4'd0;
         timer_q       <= '0;
         coin_reject_q <= 1'b0;
         timeout_q     <= 1'b0;
         vend_req_q    <= 1'b0;
         vend_item_q   <= 2'd0;
         chg_req_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         item_q        <= item_d;
         price_q       <= price_d;
         change_q      <= change_d;
         credit_q      <= credit_d;
         chg_amount_q  <= chg_amount_d;
         timer_q       <= timer_d;
         coin_reject_q <= coin_reject_d;
         timeout_q     <= timeout_d;
         vend_req_q    <= (state_d == VEND);
         vend_item_q   <= (state_d == VEND) ? item_d : 2'd0;
         chg_req_q     <= (state_d == REFUND);
         busy_q        <= (state_d != IDLE);
      end
   end

   assign vend_req    = vend_req_q;
   assign vend_item   = vend_item_q;
   assign chg_req     = chg_req_q;
   assign chg_amount  = chg_amount_q;
   assign credit      = credit_q;
   assign busy        = busy_q;
   assign coin_reject = coin_reject_q;
   assign timeout     = timeout_q;

endmodule
